// File: rtl/fault_campaign_sequencer.sv
// fault_campaign_sequencer: steps a fault-injection campaign through every fault,
// running the pattern generator per fault and counting faults the analyzer detects.
module fault_campaign_sequencer #(
    parameter int ERR_BITS  = 10,
    parameter int ERR_TOTAL = 528,
    parameter int ORA_LAT   = 1,
    parameter int PAT_LIMIT = 65535,
    parameter int DROP      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                START,
    input  logic                TPG_END,
    input  logic                ORA_RES,
    output logic                SYS_RESET,
    output logic                TPG_RESET,
    output logic                FIL_INC,
    output logic                BUSY,
    output logic                DONE,
    output logic                TIMEOUT,
    output logic [ERR_BITS-1:0] FAULT_IDX,
    output logic [ERR_BITS-1:0] ERR_COUNT
);
    typedef enum logic [2:0] {IDLE, INIT, ARM, RUN, DRAIN, EVAL, NEXT, FINISH} state_t;

    state_t              state_q, state_d;
    logic [ERR_BITS-1:0] idx_q, idx_d, cnt_q, cnt_d;
    logic [15:0]         pat_q, pat_d;
    logic [3:0]          drn_q, drn_d;
    logic                to_q, to_d, det_q, det_d;
    logic                sys_reset_q, sys_reset_d, tpg_reset_q, tpg_reset_d;
    logic                fil_inc_q, fil_inc_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        drn_d   = drn_q;
        to_d    = to_q;
        det_d   = det_q;
        case (state_q)
            IDLE, FINISH: if (START) begin
                state_d = INIT;
                idx_d   = '0;
                cnt_d   = '0;
                to_d    = 1'b0;
            end
            INIT: state_d = ARM;
            ARM: begin
                det_d   = 1'b0;
                pat_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                pat_d = pat_q + 16'd1;
                drn_d = '0;
                if (ORA_RES) det_d = 1'b1;
                // detection outranks end-of-patterns, which outranks the watchdog
                if (ORA_RES && DROP != 0) state_d = EVAL;
                else if (TPG_END) state_d = (ORA_LAT == 0) ? EVAL : DRAIN;
                else if (pat_q == 16'(PAT_LIMIT - 1)) begin
                    to_d    = 1'b1;
                    state_d = (ORA_LAT == 0) ? EVAL : DRAIN;
                end
            end
            DRAIN: begin
                if (ORA_RES) det_d = 1'b1;
                drn_d = drn_q + 4'd1;
                if (drn_q == 4'(ORA_LAT - 1)) state_d = EVAL;
            end
            EVAL: begin
                if (det_q && cnt_q != '1) cnt_d = cnt_q + ERR_BITS'(1);
                state_d = (idx_q == ERR_BITS'(ERR_TOTAL - 1)) ? FINISH : NEXT;
            end
            NEXT: begin
                idx_d   = idx_q + ERR_BITS'(1);
                state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
        sys_reset_d = state_d == INIT;
        tpg_reset_d = state_d != RUN;
        fil_inc_d   = state_d == NEXT;
        busy_d      = state_d != IDLE && state_d != FINISH;
        done_d      = state_d == FINISH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            pat_q       <= '0;
            drn_q       <= '0;
            to_q        <= 1'b0;
            det_q       <= 1'b0;
            sys_reset_q <= 1'b1;
            tpg_reset_q <= 1'b1;
            fil_inc_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            drn_q       <= drn_d;
            to_q        <= to_d;
            det_q       <= det_d;
            sys_reset_q <= sys_reset_d;
            tpg_reset_q <= tpg_reset_d;
            fil_inc_q   <= fil_inc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign SYS_RESET = sys_reset_q;
    assign TPG_RESET = tpg_reset_q;
    assign FIL_INC   = fil_inc_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign TIMEOUT   = to_q;
    assign FAULT_IDX = idx_q;
    assign ERR_COUNT = cnt_q;
endmodule

// File: tb/tb_fault_campaign_sequencer.sv
// tb_fault_campaign_sequencer: builds an expected per-cycle schedule of each campaign from
// the per-fault stimulus plan, then replays it against the sequencer cycle by cycle.
module tb_fault_campaign_sequencer;
    localparam int EB = 2;
    localparam int NF = 4;
    localparam int PL = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic START = 1'b0, TPG_END = 1'b0, ORA_RES = 1'b0;
    logic SYS_RESET, TPG_RESET, FIL_INC, BUSY, DONE, TIMEOUT;
    logic [EB-1:0] FAULT_IDX, ERR_COUNT;

    fault_campaign_sequencer #(
        .ERR_BITS(EB), .ERR_TOTAL(NF), .ORA_LAT(1), .PAT_LIMIT(PL), .DROP(1)
    ) dut (
        .clk(clk), .rst(rst), .START(START), .TPG_END(TPG_END), .ORA_RES(ORA_RES),
        .SYS_RESET(SYS_RESET), .TPG_RESET(TPG_RESET), .FIL_INC(FIL_INC), .BUSY(BUSY),
        .DONE(DONE), .TIMEOUT(TIMEOUT), .FAULT_IDX(FAULT_IDX), .ERR_COUNT(ERR_COUNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        bit         rst, st, te, orr;
        logic [9:0] exp;
    } rec_t;

    rec_t q[$];
    int tests = 0, fails = 0, fil_seen = 0, run_seen = 0, cyc = 0;
    int p_tend[NF], p_ora[NF];
    bit p_drn[NF];
    bit m_done = 0, m_to = 0;
    logic [EB-1:0] m_idx = '0, m_cnt = '0;

    task automatic push(input string nm, input bit st, te, orr, r, sys, tpg, fil, busy, done);
        rec_t x;
        x.nm = nm; x.rst = r; x.st = st; x.te = te; x.orr = orr;
        x.exp = {sys, tpg, fil, busy, done, m_to, m_idx, m_cnt};
        q.push_back(x);
    endtask

    task automatic reset_seq();
        m_idx = '0; m_cnt = '0; m_to = 0; m_done = 0;
        push("RST", 0, 0, 0, 0, 1, 1, 0, 0, 0);
        push("RST", 0, 0, 0, 0, 1, 1, 0, 0, 0);
        push("REL", 0, 0, 0, 1, 1, 1, 0, 0, 0);
        push("IDLE", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    endtask

    // per fault: RUN ends at the first of detection, TPG_END or the watchdog limit
    task automatic campaign(input bit noise, input int stop_f, input int stop_c);
        int e;
        bit drop, det;
        push("START", 1, 0, 0, 1, 0, 1, 0, 0, m_done);
        m_idx = '0; m_cnt = '0; m_to = 0; m_done = 0;
        push("INIT", noise, noise, noise, 1, 1, 1, 0, 1, 0);
        for (int f = 0; f < NF; f++) begin
            push("ARM", noise, noise, noise, 1, 0, 1, 0, 1, 0);
            e = PL;
            if (p_tend[f] != 0 && p_tend[f] < e) e = p_tend[f];
            if (p_ora[f] != 0 && p_ora[f] <= e) e = p_ora[f];
            for (int c = 1; c <= e; c++) begin
                push("RUN", noise, c == p_tend[f], c == p_ora[f], 1, 0, 0, 0, 1, 0);
                if (f == stop_f && c == stop_c) return;
            end
            drop = p_ora[f] == e;
            det = drop;
            if (!drop) begin
                if (e != p_tend[f]) m_to = 1;
                push("DRAIN", noise, noise, p_drn[f], 1, 0, 1, 0, 1, 0);
                det = p_drn[f];
            end
            push("EVAL", noise, noise, noise, 1, 0, 1, 0, 1, 0);
            if (det && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            if (f < NF - 1) begin
                push("NEXT", noise, noise, noise, 1, 0, 1, 1, 1, 0);
                m_idx = m_idx + 1'b1;
            end else m_done = 1;
        end
        push("FINISH", 0, 0, 0, 1, 0, 1, 0, 0, 1);
    endtask

    task automatic play();
        rec_t r;
        logic [9:0] got;
        fil_seen = 0;
        run_seen = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(posedge clk);
            #1;
            rst = r.rst; START = r.st; TPG_END = r.te; ORA_RES = r.orr;
            @(negedge clk);
            cyc++;
            got = {SYS_RESET, TPG_RESET, FIL_INC, BUSY, DONE, TIMEOUT, FAULT_IDX, ERR_COUNT};
            tests++;
            if (got !== r.exp) begin
                fails++;
                $display("FAIL %s cycle %0d: sys,tpg,fil,busy,done,to,idx,cnt got %b required %b",
                         r.nm, cyc, got, r.exp);
            end
            fil_seen += int'(FIL_INC);
            if (TPG_RESET === 1'b0) run_seen++;
        end
    endtask

    task automatic pin(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    initial begin
        reset_seq();
        play();

        p_tend = '{5, 5, 5, 5}; p_ora = '{0, 0, 0, 0}; p_drn = '{0, 0, 0, 0};
        campaign(0, -1, -1); play();
        pin("clean_fil", fil_seen, 3); pin("clean_run", run_seen, 20);
        pin("clean_cnt", int'(ERR_COUNT), 0); pin("clean_idx", int'(FAULT_IDX), 3);
        pin("clean_done", int'(DONE), 1);

        p_ora = '{0, 2, 0, 2};
        campaign(0, -1, -1); play();
        pin("drop_cnt", int'(ERR_COUNT), 2); pin("drop_run", run_seen, 14);
        pin("drop_fil", fil_seen, 3);

        p_ora = '{0, 0, 0, 0}; p_drn = '{1, 0, 0, 0};
        campaign(0, -1, -1); play();
        pin("drain_cnt", int'(ERR_COUNT), 1); pin("drain_to", int'(TIMEOUT), 0);

        p_drn = '{0, 0, 0, 0}; p_tend = '{0, 3, 3, 3};
        campaign(0, -1, -1); play();
        pin("wdog_run", run_seen, 17); pin("wdog_to", int'(TIMEOUT), 1);
        pin("wdog_done", int'(DONE), 1);

        p_tend = '{8, 1, 1, 1};
        campaign(0, -1, -1); play();
        pin("edge_run", run_seen, 11); pin("edge_to", int'(TIMEOUT), 0);

        p_tend = '{5, 5, 3, 5}; p_ora = '{1, 2, 3, 4};
        campaign(1, -1, -1); play();
        pin("noise_cnt", int'(ERR_COUNT), 3); pin("noise_run", run_seen, 10);
        pin("noise_fil", fil_seen, 3);

        p_tend = '{5, 5, 5, 5}; p_ora = '{0, 0, 0, 0};
        campaign(0, 2, 2);
        reset_seq();
        play();
        pin("abort_fil", fil_seen, 2); pin("abort_sys", int'(SYS_RESET), 0);
        campaign(0, -1, -1); play();
        pin("after_idx", int'(FAULT_IDX), 3); pin("after_fil", fil_seen, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
